mem_access_ctrl: RTL and testbench

- Memory-stage controller that consumes the effective address and store data produced by the execute stage.
- Turns each load or store request into a single handshaked transaction on a multi-cycle data memory.
- Holds the pipeline with a stall while the transaction is outstanding.
- Returns load data with a one-cycle done pulse, and flags misaligned, illegal, failed or timed-out accesses.

---
 rtl/mem_access_ctrl_pkg.sv | 14 +
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_timeout_cnt.sv | 31 +++
 rtl/mem_access_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller.
// FSM encoding and datapath width.
package mem_access_ctrl_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus.
// master = controller, slave = memory.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic          dm_en;
  logic          dm_wr;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_busy;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          dm_err;

  modport master (
    output dm_en, dm_wr, dm_addr, dm_wdata,
    input  dm_busy, dm_done, dm_rdata, dm_err
  );

  modport slave (
    input  dm_en, dm_wr, dm_addr, dm_wdata,
    output dm_busy, dm_done, dm_rdata, dm_err
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Access timeout counter with terminal count.
// Saturates at TIMEOUT-1 so it never wraps.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TMAX =
    CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == TMAX);

  // Clear on access start, count while outstanding.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !tc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: one handshaked
// data-memory transaction per load/store.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  input  logic          mem_rd,
  input  logic          mem_wr,
  output logic          stall,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          err,
  mem_access_ctrl_if.master dm
);

  state_t        state_q;
  state_t        state_d;
  logic          err_q;
  logic          err_d;
  logic          wr_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          req;
  logic          bad;
  logic          start;
  logic          cap;
  logic          cnt_en;
  logic          tc;

  assign req = mem_rd | mem_wr;
  assign bad = (mem_rd & mem_wr) | addr[0];

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (cnt_en),
    .tc  (tc)
  );

  // Next state, stall and error decision.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    stall   = 1'b0;
    start   = 1'b0;
    cap     = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && bad) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (req) begin
          stall   = 1'b1;
          start   = 1'b1;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (tc) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!dm.dm_busy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (dm.dm_done) begin
          cap     = ~wr_q;
          err_d   = dm.dm_err;
          state_d = RESP;
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request capture and load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (start) begin
        wr_q    <= mem_wr;
        addr_q  <= addr;
        wdata_q <= wr_data;
      end
      if (cap)
        rdata_q <= dm.dm_rdata;
    end
  end

  assign dm.dm_en    = (state_q == ISSUE);
  assign dm.dm_wr    = wr_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign done        = (state_q == RESP);
  assign err         = done & err_q;
  assign rd_data     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with
// a transaction-level timing model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic        mem_rd;
  logic        mem_wr;
  logic        stall;
  logic [15:0] rd_data;
  logic        done;
  logic        err;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] exp_rd;

  mem_access_ctrl_if dm_if ();

  mem_access_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr_data (wr_data),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .stall   (stall),
    .rd_data (rd_data),
    .done    (done),
    .err     (err),
    .dm      (dm_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic mem_quiet();
    dm_if.dm_busy  = 1'b0;
    dm_if.dm_done  = 1'b0;
    dm_if.dm_err   = 1'b0;
    dm_if.dm_rdata = 16'($urandom);
  endtask

  task automatic idle_cycle(input logic stray);
    @(negedge clk);
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    addr   = 16'($urandom);
    mem_quiet();
    dm_if.dm_done = stray;
    dm_if.dm_err  = stray;
    #1;
    check("idle_stall", stall, 0);
    check("idle_en", dm_if.dm_en, 0);
    check("idle_done", done, 0);
    check("idle_rd", rd_data, exp_rd);
  endtask

  // nbusy: cycles of dm_busy in ISSUE;
  // lat: WAIT cycle carrying dm_done (0=never).
  task automatic run_txn(input logic [15:0] a,
                         input logic [15:0] wd,
                         input logic rd,
                         input logic wr,
                         input int nbusy,
                         input int lat,
                         input logic merr,
                         input logic [15:0] rdat);
    bit legal;
    bit succ;
    int resp;
    int i;
    legal = (rd ^ wr) && !a[0];
    if (!legal) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        addr = a; wr_data = wd;
        mem_rd = rd; mem_wr = wr;
        mem_quiet();
        #1;
        check("ill_stall", stall, 0);
        check("ill_en", dm_if.dm_en, 0);
        check("ill_done", done, c == 1);
        if (c == 1) begin
          check("ill_err", err, 1);
          check("ill_rd", rd_data, exp_rd);
        end
      end
      return;
    end
    succ = (lat > 0) && (nbusy + lat <= TO - 1);
    resp = succ ? nbusy + lat + 2 : TO + 1;
    for (int c = 0; c <= resp; c++) begin
      @(negedge clk);
      addr = a; wr_data = wd;
      mem_rd = rd; mem_wr = wr;
      mem_quiet();
      i = c - 1;
      dm_if.dm_busy = (c >= 1) && (i < nbusy);
      if (c >= 1 && lat > 0 && i == nbusy + lat) begin
        dm_if.dm_done  = 1'b1;
        dm_if.dm_err   = merr;
        dm_if.dm_rdata = rdat;
      end
      if (c == resp && succ && rd)
        exp_rd = rdat;
      #1;
      check("stall", stall, c < resp);
      check("dm_en", dm_if.dm_en,
            (c >= 1) && (c < resp) && (i <= nbusy));
      if (dm_if.dm_en) begin
        check("dm_addr", dm_if.dm_addr, a);
        check("dm_wr", dm_if.dm_wr, wr);
        if (wr)
          check("dm_wdata", dm_if.dm_wdata, wd);
      end
      check("done", done, c == resp);
      if (c == resp) begin
        check("err", err, succ ? merr : 1'b1);
        check("rd_data", rd_data, exp_rd);
      end
    end
  endtask

  task automatic reset_in_wait();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      addr = 16'h0040; mem_rd = 1'b1; mem_wr = 1'b0;
      mem_quiet();
      #1;
      check("rw_stall", stall, 1);
      check("rw_en", dm_if.dm_en, c == 1);
    end
    @(negedge clk);
    rst = 1'b1; mem_rd = 1'b0;
    mem_quiet();
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 16'h0000;
    #1;
    check("rst_stall", stall, 0);
    check("rst_en", dm_if.dm_en, 0);
    check("rst_wr", dm_if.dm_wr, 0);
    check("rst_addr", dm_if.dm_addr, 0);
    check("rst_wdata", dm_if.dm_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd", rd_data, 0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
  endtask

  initial begin
    int k;
    logic rd, wr;
    logic [15:0] a;
    rst = 1'b1;
    addr = '0; wr_data = '0;
    mem_rd = 1'b0; mem_wr = 1'b0;
    mem_quiet();
    exp_rd = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check("r_stall", stall, 0);
    check("r_en", dm_if.dm_en, 0);
    check("r_wr", dm_if.dm_wr, 0);
    check("r_addr", dm_if.dm_addr, 0);
    check("r_wdata", dm_if.dm_wdata, 0);
    check("r_done", done, 0);
    check("r_err", err, 0);
    check("r_rd", rd_data, 0);
    rst = 1'b0;
    idle_cycle(1'b0);

    run_txn(16'h0010, 16'h0, 1, 0, 0, 1, 0, 16'hBEEF);
    idle_cycle(1'b0);
    run_txn(16'h0020, 16'h1234, 0, 1, 2, 1, 0,
            16'h5555);
    idle_cycle(1'b1);
    run_txn(16'h0011, 16'h0, 1, 0, 0, 1, 0, 16'h0);
    run_txn(16'h0030, 16'h0, 1, 1, 0, 1, 0, 16'h0);
    idle_cycle(1'b0);
    run_txn(16'h0050, 16'h0, 1, 0, 0, 0, 0, 16'h0);
    idle_cycle(1'b0);
    run_txn(16'h0052, 16'h0, 1, 0, 1, 2, 0, 16'hA5A5);
    run_txn(16'h0054, 16'h0, 1, 0, 0, 2, 1, 16'h7777);
    run_txn(16'h0060, 16'h0, 1, 0, 0, 1, 0, 16'h1111);
    run_txn(16'h0062, 16'h0, 1, 0, 0, 1, 0, 16'h2222);
    run_txn(16'h0064, 16'h0, 1, 0, 5, 1, 0, 16'h3333);
    idle_cycle(1'b0);
    reset_in_wait();

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      rd = (k < 5) || (k == 9);
      wr = (k >= 5);
      a = 16'($urandom);
      a[0] = ($urandom_range(0, 7) == 0);
      run_txn(a, 16'($urandom), rd, wr,
              $urandom_range(0, 4),
              $urandom_range(0, 4),
              1'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2))
        idle_cycle(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
